muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits; only 32 is supported.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, destination register index width in bits.
REQ-003 Port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1, reset, asynchronous and active-high.
REQ-005 Port i_start, input, 1, request to start an operation; sampled only in IDLE.
REQ-006 Port i_funct3, input, 3, RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port i_rs1, input, XLEN, operand A (register-file read port 0 data).
REQ-008 Port i_rs2, input, XLEN, operand B (register-file read port 1 data).
REQ-009 Port i_rd, input, REG_ADDR_WIDTH, destination register index.
REQ-010 Port i_flush, input, 1, abort any in-flight operation.
REQ-011 Port o_busy, output, 1, high whenever state is not IDLE.
REQ-012 Port o_valid, output, 1, one-cycle result strobe; drives the register-file write enable.
REQ-013 Port o_result, output, XLEN, result; meaningful only while o_valid is high.
REQ-014 Port o_rd, output, REG_ADDR_WIDTH, captured destination index; drives the register-file write address.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE.
REQ-016 In IDLE with i_start=1 and i_flush=0, the unit SHALL capture i_funct3, i_rs1, i_rs2 and i_rd on the edge; later input changes SHALL NOT affect the operation.
REQ-017 Normal path: IDLE->CALC on the capture edge, exactly 32 edges in CALC (one iteration per edge, 5-bit counter), CALC->DONE, then DONE->IDLE on the next edge.
REQ-018 o_valid SHALL be high only in DONE, i.e. for exactly one cycle, 34 edges after the capture edge inclusive.
REQ-019 Multiply SHALL use shift-add on operand magnitudes with sign fix-up: MUL gives low 32 bits; MULH is signed x signed high; MULHSU is signed rs1 x unsigned rs2 high; MULHU is unsigned high.
REQ-020 Divide SHALL use restoring division on magnitudes; the quotient is truncated toward zero and the remainder takes the dividend's sign.
REQ-021 Divide by zero SHALL bypass CALC (IDLE->DONE): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
REQ-022 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) SHALL bypass CALC: DIV gives 0x80000000; REM gives 0.
REQ-023 On a bypass, o_valid SHALL be high in the cycle after the capture edge.
REQ-024 i_start while o_busy=1 SHALL be ignored; there is no queueing.
REQ-025 i_flush=1 at an edge in CALC or DONE SHALL return the FSM to IDLE with no o_valid pulse; if i_flush and i_start are both high in IDLE, the flush wins and nothing is captured.
REQ-026 In DONE, i_start SHALL be ignored; a new op can be captured at the earliest on the first edge in IDLE.
REQ-027 rd=0 SHALL complete normally; the register file discards the write.
REQ-028 o_result and o_rd SHALL hold their values in DONE and SHALL be 0 when o_valid=0.

Reset
REQ-029 i_rst=1 SHALL force IDLE immediately, asynchronously, and clear o_busy, o_valid, o_result, o_rd and all datapath registers to 0.
REQ-030 Reset mid-operation SHALL abandon the operation with no o_valid; after reset deassertion, the first edge may capture a new op.

Verification
REQ-031 MUL with rs1=7, rs2=0xFFFFFFFD, rd=5 -> o_valid for one cycle 34 edges later, o_result=0xFFFFFFEB, o_rd=5, o_busy high throughout.
REQ-032 MULHU with rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU with rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
REQ-033 DIV with rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU with rs1=100, rs2=7 -> 14; REMU -> 2.
REQ-034 DIVU with rs1=0x1234, rs2=0 -> 0xFFFFFFFF, o_valid the cycle after capture; REMU -> 0x1234; DIV with rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-035 i_start pulsed during CALC is ignored with its result never appearing; i_flush at iteration 10 -> IDLE with no o_valid; the next op completes correctly.
REQ-036 i_rst asserted mid-CALC between edges -> o_busy=0 immediately; no o_valid after release; back-to-back ops after reset write the expected values into the register file, and reads confirm them.

Source files
------------

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between the issue stage and the RV32M multiply/divide unit
interface muldiv_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      i_start;
    logic [2:0]                i_funct3;
    logic [XLEN-1:0]           i_rs1;
    logic [XLEN-1:0]           i_rs2;
    logic [REG_ADDR_WIDTH-1:0] i_rd;
    logic                      i_flush;
    logic                      o_busy;
    logic                      o_valid;
    logic [XLEN-1:0]           o_result;
    logic [REG_ADDR_WIDTH-1:0] o_rd;

    modport master (
        output i_start, i_funct3, i_rs1, i_rs2, i_rd, i_flush,
        input  o_busy, o_valid, o_result, o_rd
    );

    modport slave (
        input  i_start, i_funct3, i_rs1, i_rs2, i_rd, i_flush,
        output o_busy, o_valid, o_result, o_rd
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M unit: 32-step shift-add multiply and restoring divide
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic    i_clk,
    input  logic    i_rst,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state, state_n;
    logic [2:0]                f_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [XLEN-1:0]           b_q;
    logic [2*XLEN-1:0]         prod;
    logic [4:0]                cnt;
    logic                      neg_q;
    logic [XLEN-1:0]           res_q;

    logic            capture, is_div, div0, ovf, bypass;
    logic            signed_a, signed_b, neg_n;
    logic [XLEN-1:0] a_mag, b_mag, bypass_res;

    assign capture  = bus.i_start && !bus.i_flush;
    assign is_div   = bus.i_funct3[2];
    assign div0     = is_div && (bus.i_rs2 == '0);
    assign ovf      = is_div && !bus.i_funct3[0] && (bus.i_rs1 == 32'h8000_0000)
                      && (bus.i_rs2 == 32'hFFFF_FFFF);
    assign bypass   = div0 || ovf;
    assign signed_a = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b010)
                      || (bus.i_funct3 == 3'b100) || (bus.i_funct3 == 3'b110);
    assign signed_b = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b100)
                      || (bus.i_funct3 == 3'b110);
    assign a_mag    = (signed_a && bus.i_rs1[XLEN-1]) ? -bus.i_rs1 : bus.i_rs1;
    assign b_mag    = (signed_b && bus.i_rs2[XLEN-1]) ? -bus.i_rs2 : bus.i_rs2;
    // Remainders follow the dividend; products and quotients follow the sign product.
    assign neg_n    = (is_div && bus.i_funct3[1])
                      ? (signed_a && bus.i_rs1[XLEN-1])
                      : ((signed_a && bus.i_rs1[XLEN-1]) ^ (signed_b && bus.i_rs2[XLEN-1]));

    always_comb begin
        bypass_res = '0;
        if (div0)
            bypass_res = bus.i_funct3[1] ? bus.i_rs1 : '1;
        else if (ovf)
            bypass_res = bus.i_funct3[1] ? '0 : 32'h8000_0000;
    end

    // One iteration of each algorithm; prod holds {acc/rem, multiplier/dividend-quotient}.
    logic [XLEN:0]     sum, rem_sh, rem_new;
    logic              ge;
    logic [2*XLEN-1:0] mul_next, div_next, step, full;
    logic [XLEN-1:0]   q_val, r_val, fin;

    always_comb begin
        sum      = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, b_q} : '0);
        mul_next = {sum, prod[XLEN-1:1]};
        rem_sh   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
        ge       = rem_sh >= {1'b0, b_q};
        rem_new  = ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
        div_next = {rem_new[XLEN-1:0], prod[XLEN-2:0], ge};
        step     = f_q[2] ? div_next : mul_next;
        full     = neg_q ? -mul_next : mul_next;
        q_val    = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        r_val    = neg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        if (f_q[2])
            fin = f_q[1] ? r_val : q_val;
        else
            fin = (f_q[1:0] == 2'b00) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (capture) state_n = bypass ? DONE : CALC;
            CALC: if (bus.i_flush) state_n = IDLE;
                  else if (cnt == 5'd31) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_q   <= '0;
            rd_q  <= '0;
            b_q   <= '0;
            prod  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            res_q <= '0;
        end else if (state == IDLE && capture) begin
            f_q   <= bus.i_funct3;
            rd_q  <= bus.i_rd;
            b_q   <= b_mag;
            prod  <= {{XLEN{1'b0}}, a_mag};
            cnt   <= '0;
            neg_q <= neg_n;
            if (bypass)
                res_q <= bypass_res;
        end else if (state == CALC && !bus.i_flush) begin
            prod <= step;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31)
                res_q <= fin;
        end
    end

    assign bus.o_busy   = (state != IDLE);
    assign bus.o_valid  = (state == DONE);
    assign bus.o_result = (state == DONE) ? res_q : '0;
    assign bus.o_rd     = (state == DONE) ? rd_q : '0;
endmodule
